rand_candidate_ctrl: RTL and testbench
======================================

Name: rand_candidate_ctrl

Overview:
- Sequences the free-running 16-bit LFSR (WORD_WIDTH/2 wide) used for RSA key generation.
- Shares it round-robin between NUM_REQ requesters, such as the p and q prime-search engines.
- Builds full WORD_WIDTH-bit prime candidates from two well-spaced LFSR samples, forcing the top bit and bit 0 to 1.
- Owns LFSR seeding: reload pulse, zero-seed substitution and stuck-at-zero detection.

Parameters:
- WORD_WIDTH, 32, candidate width; must be even and >= 8; HALF = WORD_WIDTH/2.
- NUM_REQ, 2, number of requesters; must be >= 2; IDW = $clog2(NUM_REQ).
- DEFAULT_SEED, 16'hA65A (HALF bits), seed used after reset and in place of a zero seed.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request, one bit per requester.
- seed_load  in  1  single-cycle pulse: reseed the LFSR with seed_in.
- seed_in  in  HALF  seed value, sampled when seed_load=1.
- lfsr_rand  in  HALF  LFSR state output.
- lfsr_rst  out  1  LFSR reset/seed-load strobe.
- lfsr_seed  out  HALF  seed presented to the LFSR.
- resp_valid  out  1  candidate valid.
- resp_ready  in  1  consumer accepts the candidate.
- resp_id  out  IDW  index of the served requester.
- resp_data  out  WORD_WIDTH  prime candidate.
- busy  out  1  high when the state is not IDLE.
- lfsr_stuck  out  1  sticky flag: a zero LFSR sample was captured.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; resp_valid=0, resp_id=0, resp_data=0, busy=0, lfsr_stuck=0.
  - rr_ptr=0; pending-seed flag cleared; lfsr_seed=DEFAULT_SEED.
  - lfsr_rst = rst OR (state==SEED), combinational, so the LFSR is reseeded whenever the controller is reset.
- Seed capture:
  - seed_load=1 in any state sets pend=1 and pend_seed = (seed_in==0 ? DEFAULT_SEED : seed_in).
  - A later seed_load overwrites pend_seed. Only the last value is applied.
- States: IDLE, SEED, FILL_HI, FILL_LO, RESP.
- IDLE:
  - pend (or seed_load this cycle): go to SEED; lfsr_seed <= seed value. Seeding has priority over req.
  - else any req bit high: grant the first set bit searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. Latch gid; cnt<=0; go to FILL_HI.
  - else stay.
- SEED (exactly 1 cycle):
  - lfsr_rst=1; clear pend, unless a new seed_load arrives this same cycle, in which case pend stays set with the new value.
  - Go to IDLE.
- FILL_HI:
  - cnt increments each cycle.
  - When cnt==HALF-1: hi<=lfsr_rand; cnt<=0; go to FILL_LO.
  - The HALF-cycle spacing guarantees each captured half consists of fully shifted bits.
- FILL_LO:
  - When cnt==HALF-1: lo<=lfsr_rand; go to RESP.
  - resp_data <= {1'b1, hi[HALF-2:0], lo[HALF-1:1], 1'b1}; resp_id<=gid; resp_valid<=1.
- Stuck detection: a zero capture of either hi or lo sets lfsr_stuck=1. It is cleared only by rst. The response is still produced.
- Latency:
  - IDLE sampling req in cycle 0 puts resp_valid high in cycle 2*HALF+1.
  - With WORD_WIDTH=32, that is cycle 33.
- RESP:
  - resp_valid, resp_id and resp_data are held stable while resp_ready=0. No LFSR capture happens.
  - On resp_valid&&resp_ready: resp_valid<=0; rr_ptr<=(gid+1) mod NUM_REQ; go to IDLE.
- Requester protocol:
  - A requester must deassert req in the cycle after its handshake if it wants no further candidate.
  - Holding req high means back-to-back service, subject to round-robin.
  - A req drop during FILL or RESP is ignored; the candidate is still delivered.
- A seed_load arriving mid-request never disturbs the in-flight candidate. It is applied in the first IDLE after the handshake.
- rst during any state aborts immediately: the in-flight candidate is discarded and no response is issued.

Test Plan:
1. Reset; hold req=2'b01 only.
   -> lfsr_rst high during rst; resp_valid rises exactly 33 cycles after the first IDLE sample; resp_id=0.
   -> resp_data[31]=1, resp_data[0]=1; remaining bits match a golden LFSR model seeded with 16'hA65A.
2. req=2'b11 held, resp_ready=1.
   -> four consecutive responses with resp_id 0,1,0,1.
   -> each response arrives 34 cycles after the previous one (1 IDLE cycle + 33).
3. One request; resp_ready=0 for 10 cycles after resp_valid.
   -> resp_data and resp_id stable all 10 cycles; busy=1.
   -> handshake on cycle 11; busy=0 the following cycle.
4. In IDLE: seed_load with seed_in=0 -> next cycle lfsr_rst=1 for one cycle, lfsr_seed=16'hA65A.
   In FILL_HI: seed_load with seed_in=16'h0001 -> no lfsr_rst until after the response handshake; then a single lfsr_rst cycle with lfsr_seed=16'h0001 before the next grant.
5. Drive lfsr_rand=0 constantly; one request.
   -> resp_data=32'h80000001; lfsr_stuck=1 and stays 1 across further requests until rst.
6. Assert rst for one cycle while in FILL_LO (req=2'b10 pending).
   -> following cycle resp_valid=0, busy=0, lfsr_stuck=0, rr_ptr=0.
   -> with req=2'b11, the next grant goes to requester 0.

Source files
------------

// File: rtl/rand_candidate_ctrl.sv
// Prime-candidate builder for RSA keygen: arbitrates a shared HALF-bit LFSR between
// requesters, splices two spaced samples into a WORD_WIDTH-bit odd, top-bit-set candidate.
module rand_candidate_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter logic [WORD_WIDTH/2-1:0] DEFAULT_SEED = 16'hA65A,
  localparam int HALF = WORD_WIDTH / 2,
  localparam int IDW  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  seed_load,
  input  logic [HALF-1:0]       seed_in,
  input  logic [HALF-1:0]       lfsr_rand,
  output logic                  lfsr_rst,
  output logic [HALF-1:0]       lfsr_seed,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WORD_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic                  lfsr_stuck
);
  localparam int CW = $clog2(HALF);

  typedef enum logic [2:0] {IDLE, SEED, FILL_HI, FILL_LO, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr, gid, gnt_idx;
  logic            gnt_found;
  logic [CW-1:0]   cnt;
  logic [HALF-2:0] hi;
  logic            pend;
  logic [HALF-1:0] pend_seed, seed_fix;

  assign seed_fix = (seed_in == '0) ? DEFAULT_SEED : seed_in;
  assign lfsr_rst = rst | (state == SEED);
  assign busy     = (state != IDLE);

  // First asserted request at or after rr_ptr, wrapping
  always_comb begin
    int k;
    k         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!gnt_found && req[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gid        <= '0;
      cnt        <= '0;
      hi         <= '0;
      pend       <= 1'b0;
      pend_seed  <= DEFAULT_SEED;
      lfsr_seed  <= DEFAULT_SEED;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      lfsr_stuck <= 1'b0;
    end else begin
      if (seed_load) begin
        pend      <= 1'b1;
        pend_seed <= seed_fix;
      end
      case (state)
        IDLE: begin
          if (pend || seed_load) begin
            lfsr_seed <= seed_load ? seed_fix : pend_seed;
            state     <= SEED;
          end else if (gnt_found) begin
            gid   <= gnt_idx;
            cnt   <= '0;
            state <= FILL_HI;
          end
        end
        SEED: begin
          if (!seed_load) pend <= 1'b0;
          state <= IDLE;
        end
        FILL_HI: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(HALF - 1)) begin
            hi    <= lfsr_rand[HALF-2:0];
            cnt   <= '0;
            state <= FILL_LO;
            if (lfsr_rand == '0) lfsr_stuck <= 1'b1;
          end
        end
        FILL_LO: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(HALF - 1)) begin
            resp_data  <= {1'b1, hi, lfsr_rand[HALF-1:1], 1'b1};
            resp_id    <= gid;
            resp_valid <= 1'b1;
            state      <= RESP;
            if (lfsr_rand == '0) lfsr_stuck <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= IDW'((int'(gid) + 1) % NUM_REQ);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rand_candidate_ctrl.sv
// Bench for rand_candidate_ctrl: behavioural LFSR environment, scoreboard monitor,
// vector table of single transactions and hand-written seeding/stall/reset sequences.
module tb_rand_candidate_ctrl;
  localparam int W = 32;
  localparam int H = 16;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, seed_load, resp_ready, force_zero;
  logic [N-1:0]  req;
  logic [H-1:0]  seed_in, lfsr_rand, lfsr_seed;
  logic          lfsr_rst, resp_valid, busy, lfsr_stuck;
  logic [0:0]    resp_id;
  logic [W-1:0]  resp_data;

  rand_candidate_ctrl #(.WORD_WIDTH(W), .NUM_REQ(N), .DEFAULT_SEED(16'hA65A)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .lfsr_rand(lfsr_rand), .lfsr_rst(lfsr_rst), .lfsr_seed(lfsr_seed),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy), .lfsr_stuck(lfsr_stuck)
  );

  function automatic logic [H-1:0] step(input logic [H-1:0] s);
    return {s[H-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  function automatic logic [H-1:0] stepn(input logic [H-1:0] s, input int n);
    logic [H-1:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = step(t);
    return t;
  endfunction
  function automatic logic [W-1:0] cand(input logic [H-1:0] hv, input logic [H-1:0] lv);
    return {1'b1, hv[H-2:0], lv[H-1:1], 1'b1};
  endfunction

  // LFSR the controller drives
  logic [H-1:0] lfsr_m = '0;
  always @(posedge clk) lfsr_m <= lfsr_rst ? lfsr_seed : step(lfsr_m);
  assign lfsr_rand = force_zero ? '0 : lfsr_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [0:0] id; logic [W-1:0] data; int due; } exp_t;
  exp_t sbq[$];

  logic         rst_q = 1'b1;
  logic [N-1:0] req_q = '0;
  always @(posedge clk) begin
    rst_q <= rst;
    req_q <= req;
    cyc   <= cyc + 1;
  end

  // Scoreboard: predict at grant, compare at resp_valid rise
  logic [0:0] rr_m = '0, last_id = '0;
  logic       pv = 1'b0, pb = 1'b0;
  always @(negedge clk) begin
    exp_t e, g;
    logic [H-1:0] hv, lv;
    if (rst_q) begin
      sbq.delete();
      rr_m = '0; pv = 1'b0; pb = 1'b0;
    end else begin
      if (busy && !pb && !lfsr_rst) begin
        e.id = req_q[rr_m] ? rr_m : ~rr_m;
        hv = force_zero ? '0 : stepn(lfsr_m, H - 1);
        lv = force_zero ? '0 : stepn(lfsr_m, 2 * H - 1);
        e.data = cand(hv, lv);
        e.due = cyc + 2 * H;
        sbq.push_back(e);
      end
      if (resp_valid && !pv) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: resp_valid with no pending grant (cycle %0d)", cyc);
        end else begin
          g = sbq.pop_front();
          chk("sb_data", resp_data, g.data);
          chk("sb_id", W'(resp_id), W'(g.id));
          chk("sb_latency", W'(cyc), W'(g.due));
          last_id = g.id;
        end
      end
      if (!resp_valid && pv) rr_m = last_id + 1'b1;
      pv = resp_valid;
      pb = busy;
    end
  end

  task automatic wait_valid(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid) begin c = cyc; break; end
    end
    if (c < 0) begin
      checks++; errors++;
      $display("FAIL valid_timeout: got no resp_valid expected one within 300 cycles");
    end
  endtask

  task automatic do_txn(input logic [N-1:0] r, input logic [0:0] e_id, output logic [W-1:0] d);
    int c;
    @(negedge clk);
    req = r; resp_ready = 1'b1;
    wait_valid(c);
    d = resp_data;
    chk("txn_id", W'(resp_id), W'(e_id));
    @(negedge clk);
    req = '0;
  endtask

  typedef struct { logic [N-1:0] req; logic [0:0] id; } vec_t;
  vec_t tbl[6];

  initial begin
    int c, r0, prev, nrst;
    logic [W-1:0] d, d0;
    logic [0:0] i0;
    tbl[0] = '{2'b01, 1'b0}; tbl[1] = '{2'b11, 1'b1}; tbl[2] = '{2'b10, 1'b1};
    tbl[3] = '{2'b11, 1'b0}; tbl[4] = '{2'b01, 1'b0}; tbl[5] = '{2'b11, 1'b1};

    rst = 1'b1; req = 2'b01; seed_load = 1'b0; seed_in = '0;
    resp_ready = 1'b1; force_zero = 1'b0;

    // 1: reset values, first latency, golden data
    repeat (3) @(negedge clk);
    chk("rst_lfsr_rst", W'(lfsr_rst), 1);
    chk("rst_valid", W'(resp_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_stuck", W'(lfsr_stuck), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_id", W'(resp_id), 0);
    chk("rst_seed", W'(lfsr_seed), W'(16'hA65A));
    rst = 1'b0; r0 = cyc;
    wait_valid(c);
    chk("t1_latency", W'(c - r0), 33);
    chk("t1_id", W'(resp_id), 0);
    chk("t1_data", resp_data, cand(stepn(16'hA65A, 16), stepn(16'hA65A, 32)));
    @(negedge clk); req = '0;

    // 2: back-to-back round robin
    @(negedge clk); rst = 1'b1; req = 2'b11;
    @(negedge clk); @(negedge clk); rst = 1'b0; r0 = cyc; prev = r0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(c);
      chk("t2_id", W'(resp_id), W'(i % 2));
      chk("t2_spacing", W'(c - prev), (i == 0) ? 33 : 34);
      prev = c;
    end
    @(negedge clk); req = '0;

    // vector table
    foreach (tbl[i]) do_txn(tbl[i].req, tbl[i].id, d);

    // 3: stalled consumer
    @(negedge clk); req = 2'b10; resp_ready = 1'b0;
    wait_valid(c);
    d0 = resp_data; i0 = resp_id;
    chk("t3_id", W'(i0), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", W'(resp_valid), 1);
      chk("t3_hold_data", resp_data, d0);
      chk("t3_hold_id", W'(resp_id), W'(i0));
      chk("t3_busy", W'(busy), 1);
    end
    resp_ready = 1'b1; req = '0;
    @(negedge clk);
    chk("t3_busy_after", W'(busy), 0);
    chk("t3_valid_after", W'(resp_valid), 0);

    // 4a: zero seed in IDLE
    @(negedge clk); seed_load = 1'b1; seed_in = '0;
    @(negedge clk); seed_load = 1'b0;
    chk("t4_seed_strobe", W'(lfsr_rst), 1);
    chk("t4_seed_default", W'(lfsr_seed), W'(16'hA65A));
    @(negedge clk);
    chk("t4_strobe_single", W'(lfsr_rst), 0);
    // 4b: seed during fill is deferred until after the handshake
    req = 2'b01; resp_ready = 1'b1;
    repeat (5) @(negedge clk);
    seed_load = 1'b1; seed_in = 16'h0001;
    nrst = 0; c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seed_load = 1'b0;
      if (lfsr_rst) nrst++;
      if (resp_valid) begin c = cyc; break; end
    end
    chk("t4_no_early_rst", W'(nrst), 0);
    chk("t4_valid_seen", W'(c >= 0), 1);
    chk("t4_id", W'(resp_id), 0);
    @(negedge clk);
    chk("t4_idle_no_rst", W'(lfsr_rst), 0);
    @(negedge clk);
    chk("t4_deferred_rst", W'(lfsr_rst), 1);
    chk("t4_deferred_seed", W'(lfsr_seed), W'(16'h0001));
    @(negedge clk);
    chk("t4_rst_single", W'(lfsr_rst), 0);
    chk("t4_idle_busy", W'(busy), 0);
    wait_valid(c);
    chk("t4_id2", W'(resp_id), 0);
    chk("t4_data2", resp_data, cand(stepn(16'h0001, 16), stepn(16'h0001, 32)));
    @(negedge clk); req = '0;

    // 5: stuck-at-zero LFSR
    force_zero = 1'b1;
    do_txn(2'b01, 1'b0, d);
    chk("t5_data", d, 32'h80000001);
    chk("t5_stuck", W'(lfsr_stuck), 1);
    do_txn(2'b10, 1'b1, d);
    chk("t5_stuck_hold", W'(lfsr_stuck), 1);
    force_zero = 1'b0;
    do_txn(2'b01, 1'b0, d);
    chk("t5_stuck_sticky", W'(lfsr_stuck), 1);

    // 6: reset mid-FILL_LO aborts
    @(negedge clk); req = 2'b10;
    repeat (22) @(negedge clk);
    rst = 1'b1; req = 2'b11;
    @(negedge clk); rst = 1'b0;
    chk("t6_valid", W'(resp_valid), 0);
    chk("t6_busy", W'(busy), 0);
    chk("t6_stuck", W'(lfsr_stuck), 0);
    do_txn(2'b11, 1'b0, d);
    repeat (2) @(negedge clk);
    chk("sb_drained", W'(sbq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
